// File: rtl/axis_msg_arbiter.sv
// Round-robin, packet-locked merge of NUM_PORTS byte-wide AXI-Stream sources into one
// fully registered output stream. Overlong packets are cut at MAX_LEN beats with a forced
// tlast and the rest of the source packet is consumed and dropped.
module axis_msg_arbiter #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned MAX_LEN   = 64
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [8*NUM_PORTS-1:0] i_tdata,
    input  logic [NUM_PORTS-1:0]   i_tlast,
    input  logic [NUM_PORTS-1:0]   i_tvalid,
    output logic [NUM_PORTS-1:0]   o_tready,
    output logic [7:0]             o_tdata,
    output logic                   o_tlast,
    output logic                   o_tvalid,
    input  logic                   i_tready
);

    localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    // Count must reach MAX_LEN-1 for the truncation compare, plus one for the increment.
    localparam int unsigned CW = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0] LastCnt = CW'(MAX_LEN - 1);
    localparam logic [PW-1:0] LastPort = PW'(NUM_PORTS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StFwd,
        StDrain
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] grant_q, grant_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    tdata_q, tdata_d;
    logic          tlast_q, tlast_d;
    logic          tvalid_q, tvalid_d;

    logic          req_any;
    logic [PW-1:0] pick;
    logic [7:0]    sel_data;
    logic          sel_last;
    logic          sel_valid;
    logic          ready_g;
    logic [PW-1:0] ptr_next;

    // Round-robin search starting at ptr; lowest offset from ptr wins.
    always_comb begin
        logic [PW-1:0] idx;
        req_any = 1'b0;
        pick    = '0;
        idx     = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            idx = PW'((int'(ptr_q) + i) % int'(NUM_PORTS));
            if (i_tvalid[idx]) begin
                req_any = 1'b1;
                pick    = idx;
            end
        end
    end

    // Mux of the granted source and fan-out of its ready.
    always_comb begin
        sel_data  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        o_tready  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (PW'(p) == grant_q) begin
                sel_data    = i_tdata[8*p +: 8];
                sel_last    = i_tlast[p];
                sel_valid   = i_tvalid[p];
                o_tready[p] = ready_g;
            end
        end
    end

    assign ptr_next = (grant_q == LastPort) ? '0 : grant_q + 1'b1;

    // Next-state logic: arbitration, forwarding into the output slice, and draining.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q & ~i_tready;
        ready_g  = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_any) begin
                    grant_d = pick;
                    cnt_d   = '0;
                    state_d = StFwd;
                end
            end
            StFwd: begin
                // Single-entry slice: accept when empty or being emptied this cycle.
                ready_g = ~tvalid_q | i_tready;
                if (sel_valid && ready_g) begin
                    tdata_d  = sel_data;
                    tvalid_d = 1'b1;
                    tlast_d  = sel_last | (cnt_q == LastCnt);
                    cnt_d    = cnt_q + CW'(1);
                    if (sel_last) begin
                        state_d = StIdle;
                        ptr_d   = ptr_next;
                    end else if (cnt_q == LastCnt) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Dropped beats never touch the output register, so ignore i_tready.
                ready_g = 1'b1;
                if (sel_valid && sel_last) begin
                    state_d = StIdle;
                    ptr_d   = ptr_next;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign o_tdata  = tdata_q;
    assign o_tlast  = tlast_q;
    assign o_tvalid = tvalid_q;

endmodule

// File: tb/tb_axis_msg_arbiter.sv
// Bench for axis_msg_arbiter (NUM_PORTS=4, MAX_LEN=4): cycle tables, directed corner cases
// and a randomized packet scoreboard.
module tb_axis_msg_arbiter;

    localparam int unsigned NP   = 4;
    localparam int unsigned ML   = 4;
    localparam int          NPKT = 2000;

    logic          clk = 1'b0;
    logic          i_rst;
    logic [8*NP-1:0] i_tdata;
    logic [NP-1:0] i_tlast;
    logic [NP-1:0] i_tvalid;
    logic [NP-1:0] o_tready;
    logic [7:0]    o_tdata;
    logic          o_tlast;
    logic          o_tvalid;
    logic          i_tready;

    axis_msg_arbiter #(
        .NUM_PORTS (NP),
        .MAX_LEN   (ML)
    ) dut (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_tdata  (i_tdata),
        .i_tlast  (i_tlast),
        .i_tvalid (i_tvalid),
        .o_tready (o_tready),
        .o_tdata  (o_tdata),
        .o_tlast  (o_tlast),
        .o_tvalid (o_tvalid),
        .i_tready (i_tready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic [31:0] dat;
        logic        rdy;
        logic [3:0]  e_rdy;
        logic        e_v;
        logic [7:0]  e_d;
        logic        e_l;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t       vq[$];
    logic [8:0] src_q[NP][$];
    logic [8:0] exp_q[NP][$];
    logic [8:0] out_q[$];
    logic [NP-1:0] vld_r;
    bit         rand_vld;
    logic       p_v, p_r, p_l;
    logic [7:0] p_d;
    logic       s_v, s_l;
    logic [7:0] s_d;
    logic [3:0] s_trdy;
    int         lp;
    logic [8:0] e4[6];
    logic [5:0] seq[NP];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_rst    = 1'b1;
        i_tvalid = '0;
        i_tlast  = '0;
        i_tdata  = '0;
        i_tready = 1'b0;
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        vld_r = '0;
        p_v   = 1'b0;
        for (int p = 0; p < NP; p++) begin
            src_q[p].delete();
            exp_q[p].delete();
        end
        out_q.delete();
    endtask

    task automatic add_vec(input logic [3:0] vld, input logic [3:0] lst, input logic [31:0] dat,
                           input logic rdy, input logic [3:0] e_rdy, input logic e_v,
                           input logic [7:0] e_d, input logic e_l);
        vec_t v;
        v.vld = vld; v.lst = lst; v.dat = dat; v.rdy = rdy;
        v.e_rdy = e_rdy; v.e_v = e_v; v.e_d = e_d; v.e_l = e_l;
        vq.push_back(v);
    endtask

    task automatic run_table(input string tag);
        foreach (vq[i]) begin
            @(negedge clk);
            i_tvalid = vq[i].vld;
            i_tlast  = vq[i].lst;
            i_tdata  = vq[i].dat;
            i_tready = vq[i].rdy;
            #1;
            chk($sformatf("%s_c%0d_tready", tag, i), 32'(o_tready), 32'(vq[i].e_rdy));
            chk($sformatf("%s_c%0d_tvalid", tag, i), 32'(o_tvalid), 32'(vq[i].e_v));
            if (vq[i].e_v) begin
                chk($sformatf("%s_c%0d_tdata", tag, i), 32'(o_tdata), 32'(vq[i].e_d));
                chk($sformatf("%s_c%0d_tlast", tag, i), 32'(o_tlast), 32'(vq[i].e_l));
            end
        end
        vq.delete();
    endtask

    // One cycle of reactive AXI sources and sink; handshakes are resolved before the edge.
    task automatic step(input logic rdy, input logic rst_in);
        logic [31:0] d;
        logic [3:0]  l;
        @(negedge clk);
        for (int p = 0; p < NP; p++) begin
            if (!vld_r[p] && src_q[p].size() > 0)
                vld_r[p] = rand_vld ? ($urandom_range(0, 99) < 70) : 1'b1;
            d[8*p +: 8] = vld_r[p] ? src_q[p][0][7:0] : 8'($urandom);
            l[p]        = vld_r[p] ? src_q[p][0][8] : 1'($urandom);
        end
        i_rst    = rst_in;
        i_tvalid = vld_r;
        i_tdata  = d;
        i_tlast  = l;
        i_tready = rdy;
        #1;
        s_v = o_tvalid; s_d = o_tdata; s_l = o_tlast; s_trdy = o_tready;
        chk("tready_onehot0", 32'($countones(o_tready) <= 1), 1);
        if (p_v && !p_r) begin
            chk("axi_hold_valid", 32'(o_tvalid), 1);
            chk("axi_hold_data", 32'({o_tlast, o_tdata}), 32'({p_l, p_d}));
        end
        p_v = o_tvalid && !rst_in;
        p_r = rdy;
        p_d = o_tdata;
        p_l = o_tlast;
        if (!rst_in) begin
            for (int p = 0; p < NP; p++) begin
                if (vld_r[p] && o_tready[p]) begin
                    void'(src_q[p].pop_front());
                    vld_r[p] = 1'b0;
                end
            end
            if (o_tvalid && rdy) out_q.push_back({o_tlast, o_tdata});
        end
    endtask

    task automatic sb_beat(input logic [8:0] b);
        if (lp < 0) lp = int'(b[7:6]);
        chk("rnd_beat_expected", 32'(exp_q[lp].size() > 0), 1);
        if (exp_q[lp].size() > 0) chk("rnd_beat", 32'(b), 32'(exp_q[lp].pop_front()));
        if (b[8]) lp = -1;
    endtask

    function automatic logic [31:0] out_at(input int i);
        return (i < out_q.size()) ? 32'(out_q[i]) : 32'h1000;
    endfunction

    initial begin
        int acc[NP];
        int m, gp, cyc;
        bit done;
        i_rst = 1'b0; i_tvalid = '0; i_tlast = '0; i_tdata = '0; i_tready = 1'b0;
        rand_vld = 1'b0;
        lp = -1;

        do_reset();
        #1;
        chk("reset_tvalid", 32'(o_tvalid), 0);
        chk("reset_tdata", 32'(o_tdata), 0);
        chk("reset_tlast", 32'(o_tlast), 0);
        chk("reset_tready", 32'(o_tready), 0);

        // Port 2 two-beat packet from reset: first output on cycle 2, back-to-back.
        add_vec(4'b0100, 4'b0000, 32'h0041_0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0);
        add_vec(4'b0100, 4'b0000, 32'h0041_0000, 1'b1, 4'b0100, 1'b0, 8'h00, 1'b0);
        add_vec(4'b0100, 4'b0100, 32'h0042_0000, 1'b1, 4'b0100, 1'b1, 8'h41, 1'b0);
        add_vec(4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b1, 8'h42, 1'b1);
        add_vec(4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0);
        add_vec(4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0);
        run_table("t2");

        // All ports busy with 3-byte packets: grant order 0,1,2,3,0, one gap per packet.
        do_reset();
        foreach (acc[p]) acc[p] = 0;
        for (int n = 0; n < 22; n++) begin
            vec_t v;
            v.vld = 4'hf;
            v.dat = 32'h1312_1110;
            v.rdy = 1'b1;
            for (int p = 0; p < NP; p++) v.lst[p] = (acc[p] % 3 == 2);
            m  = n % 4;
            gp = (n / 4) % 4;
            v.e_rdy = (m == 0) ? 4'b0000 : (4'b0001 << gp);
            if (m != 0) acc[gp]++;
            if (n >= 2 && ((n - 2) % 4) != 3) begin
                v.e_v = 1'b1;
                v.e_d = 8'h10 + 8'(((n - 2) / 4) % 4);
                v.e_l = ((n - 2) % 4 == 2);
            end else begin
                v.e_v = 1'b0;
                v.e_d = 8'h00;
                v.e_l = 1'b0;
            end
            vq.push_back(v);
        end
        run_table("t1");

        // Toggling sink ready during a 4-beat packet.
        do_reset();
        src_q[0] = '{9'h0a0, 9'h0a1, 9'h0a2, 9'h1a3};
        for (int c = 0; c < 20; c++) begin
            step(1'((c % 2) == 0), 1'b0);
            if (s_v && !i_tready) chk("t3_stall_tready", 32'(s_trdy), 0);
        end
        chk("t3_count", out_q.size(), 4);
        chk("t3_b0", out_at(0), 32'h0a0);
        chk("t3_b1", out_at(1), 32'h0a1);
        chk("t3_b2", out_at(2), 32'h0a2);
        chk("t3_b3", out_at(3), 32'h1a3);

        // Truncation: port 1 sends 7 beats, port 2 waits; drain ignores sink ready.
        do_reset();
        src_q[1] = '{9'h051, 9'h052, 9'h053, 9'h054, 9'h055, 9'h056, 9'h157};
        src_q[2] = '{9'h061, 9'h162};
        e4 = '{9'h051, 9'h052, 9'h053, 9'h154, 9'h061, 9'h162};
        for (int c = 0; c < 40 && out_q.size() < 6; c++) begin
            step(1'(!(c >= 5 && c <= 7)), 1'b0);
            if (c >= 5 && c <= 7) chk($sformatf("t4_drain_tready_c%0d", c), 32'(s_trdy), 32'h2);
        end
        repeat (4) step(1'b1, 1'b0);
        chk("t4_count", out_q.size(), 6);
        for (int i = 0; i < 6; i++) chk($sformatf("t4_b%0d", i), out_at(i), 32'(e4[i]));
        chk("t4_src1_consumed", src_q[1].size(), 0);

        // Reset on the 2nd beat of a packet: outputs clear and the rr pointer returns to 0.
        do_reset();
        src_q[1] = '{9'h111};
        repeat (4) step(1'b1, 1'b0);
        src_q[2] = '{9'h021, 9'h022, 9'h123};
        for (int c = 0; c < 10 && src_q[2].size() == 3; c++) step(1'b1, 1'b0);
        chk("t5_first_beat_taken", src_q[2].size(), 2);
        step(1'b1, 1'b1);
        for (int p = 0; p < NP; p++) src_q[p].delete();
        vld_r = '0;
        out_q.delete();
        step(1'b1, 1'b0);
        chk("t5_rst_tvalid", 32'(s_v), 0);
        chk("t5_rst_tdata", 32'(s_d), 0);
        chk("t5_rst_tlast", 32'(s_l), 0);
        chk("t5_rst_tready", 32'(s_trdy), 0);
        src_q[0] = '{9'h101};
        src_q[3] = '{9'h131};
        repeat (10) step(1'b1, 1'b0);
        chk("t5_count", out_q.size(), 2);
        chk("t5_first_port0", out_at(0), 32'h101);
        chk("t5_second_port3", out_at(1), 32'h131);

        // Randomized packets: each output packet must equal the next truncated packet
        // of the port named in its bytes.
        do_reset();
        rand_vld = 1'b1;
        lp = -1;
        foreach (seq[p]) seq[p] = '0;
        for (int k = 0; k < NPKT; k++) begin
            int p, len;
            p   = int'($urandom_range(0, NP - 1));
            len = int'($urandom_range(1, 7));
            for (int i = 0; i < len; i++) begin
                logic [7:0] b;
                b = {2'(p), seq[p]};
                seq[p] = seq[p] + 6'd1;
                src_q[p].push_back({i == len - 1, b});
                if (i < int'(ML)) exp_q[p].push_back({(i == len - 1) || (i == int'(ML) - 1), b});
            end
        end
        done = 1'b0;
        for (cyc = 0; cyc < 60000 && !done; cyc++) begin
            step(1'($urandom_range(0, 99) < 70), 1'b0);
            while (out_q.size() > 0) sb_beat(out_q.pop_front());
            done = 1'b1;
            for (int p = 0; p < NP; p++)
                if (src_q[p].size() != 0 || exp_q[p].size() != 0) done = 1'b0;
        end
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("rnd_src%0d_empty", p), src_q[p].size(), 0);
            chk($sformatf("rnd_exp%0d_empty", p), exp_q[p].size(), 0);
        end
        chk("rnd_packet_closed", lp, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
